matrix_result_tx: RTL
=====================

Name: matrix_result_tx

Overview:
Downstream stage of the 3x3 matrix multiplier. Snapshots the finished result matrix C when the multiplier signals completion. Formats each entry as uppercase ASCII hex: entries within a row are space-separated, and each row ends with CR LF. Streams the bytes one at a time into the existing uart_tx through its tx_start/tx_busy handshake, so results are human-readable on a terminal.

Parameters:
DIM, 3, matrix dimension; DIM*DIM entries are sent.
RES_WIDTH, 8, bits per result entry; must be a multiple of 4; HEX_DIGITS = RES_WIDTH/4.
ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before treating the byte as accepted.

Ports:
clk  in  1  system clock
rst  in  1  reset
res_flat  in  DIM*DIM*RES_WIDTH  flattened C matrix; entry n at bits [n*RES_WIDTH +: RES_WIDTH], row-major
res_valid  in  1  one-cycle pulse from the multiplier when res_flat is final (calc_done rising edge)
tx_busy  in  1  busy flag from uart_tx
tx_data  out  8  byte presented to uart_tx
tx_start  out  1  one-cycle start strobe to uart_tx
busy  out  1  high from capture until the last byte has been accepted
done  out  1  one-cycle pulse after the final byte's tx_busy falls

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: tx_data=8'h00, tx_start=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-transfer aborts immediately; no further tx_start is issued. The snapshot is discarded.
- IDLE: on res_valid, latch res_flat into a snapshot register, clear entry/digit counters, set busy=1, and go to LOAD on the next cycle.
- res_valid while busy=1 is ignored; the snapshot is not overwritten.
- LOAD: compute the next byte into tx_data and go to SEND.
  - Byte order per entry: HEX_DIGITS hex chars, MSB nibble first.
  - After each entry: 8'h20 (space) if column < DIM-1; otherwise 8'h0D then 8'h0A.
- Hex mapping: 0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46 (uppercase only).
- SEND: wait until tx_busy==0, then assert tx_start for exactly one cycle with tx_data stable, and go to WAIT_ACK. tx_data holds its value until the next LOAD.
- WAIT_ACK: wait for tx_busy==1, then go to WAIT_DONE. If ACK_TIMEOUT cycles elapse without tx_busy rising, go to WAIT_DONE anyway.
- WAIT_DONE: when tx_busy==0, advance the byte position.
  - If the byte just sent was the final LF of the last row, go to DONE.
  - Otherwise go to LOAD.
- DONE: pulse done=1 for one cycle, clear busy, return to IDLE. A new res_valid is accepted the following cycle.
- Total bytes per matrix = DIM*DIM*HEX_DIGITS + DIM*(DIM-1) + 2*DIM. That is 30 for the defaults.
- Minimum spacing between tx_start pulses is 4 cycles (LOAD, SEND, WAIT_ACK, WAIT_DONE), regardless of how fast uart_tx is.
- tx_start is never asserted while tx_busy==1 and never for two consecutive cycles.
- Counters: entry index 0..DIM*DIM-1, column 0..DIM-1, digit 0..HEX_DIGITS-1, separator phase 0..1. Widths are $clog2-based with no wrap-around. The entry counter stops at the last entry.

Decomposition:
- Shared package/include:
  - State encoding: IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, DONE.
  - ASCII constants: SPACE 8'h20, CR 8'h0D, LF 8'h0A, ZERO 8'h30, ALPHA 8'h37 offset.
- One combinational sub-module, nibble_to_ascii: 4-bit in, 8-bit ASCII out. It is instantiated once on the selected nibble.

Test Plan:
1. Pulse res_valid with C = {01,02,03,04,05,06,07,08,09} hex, uart_tx model busy for 10 cycles per byte.
   -> 30 bytes, exactly "01 02 03\r\n04 05 06\r\n07 08 09\r\n"; done pulses once; busy falls in the same cycle.
2. C entries all 8'hFF and 8'hA0 alternating.
   -> chars 'F'=8'h46 and 'A'=8'h41, '0'=8'h30; no lowercase.
3. Pulse res_valid again during byte 5 with different data.
   -> output still matches the first snapshot; second pulse ignored; no extra bytes.
4. Assert rst for 1 cycle during byte 12.
   -> tx_start=0, busy=0, tx_data=0 next cycle; no more strobes.
   -> A fresh res_valid then produces a full 30-byte stream from "0".
5. uart_tx model never raises tx_busy.
   -> each byte advances after 16 timeout cycles; 30 strobes total; done pulses.
6. Throughout every scenario, check that no tx_start coincides with tx_busy=1, no two consecutive cycles have tx_start=1, and tx_data is stable during each strobe.

Source files
------------

// File: rtl/matrix_result_tx_pkg.sv
// rtl/matrix_result_tx_pkg.sv - shared states, ASCII constants and width helper for matrix_result_tx
package matrix_result_tx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5
  } tx_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  // 'A' minus 10, so nibble values 10..15 land on 'A'..'F'
  localparam logic [7:0] ASCII_ALPHA = 8'h37;

  // Counter width that never collapses to zero bits for a range of one
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_result_tx_nibble_to_ascii.sv
// rtl/matrix_result_tx_nibble_to_ascii.sv - 4-bit value to uppercase ASCII hex character
module nibble_to_ascii
  import matrix_result_tx_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Digits map onto '0'..'9', letters onto uppercase 'A'..'F'
  always_comb begin
    ascii = ASCII_ZERO;
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else begin
      ascii = ASCII_ALPHA + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/matrix_result_tx.sv
// rtl/matrix_result_tx.sv - formats a snapshot of the result matrix as ASCII hex rows into uart_tx
module matrix_result_tx
  import matrix_result_tx_pkg::*;
#(
  parameter int DIM         = 3,
  parameter int RES_WIDTH   = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIM*DIM*RES_WIDTH-1:0] res_flat,
  input  logic                         res_valid,
  input  logic                         tx_busy,
  output logic [7:0]                   tx_data,
  output logic                         tx_start,
  output logic                         busy,
  output logic                         done
);

  localparam int HEX_DIGITS = RES_WIDTH / 4;
  localparam int ENTRIES    = DIM * DIM;
  localparam int ENT_W      = cnt_width(ENTRIES);
  localparam int COL_W      = cnt_width(DIM);
  localparam int DIG_W      = cnt_width(HEX_DIGITS);
  localparam int TMO_W      = cnt_width(ACK_TIMEOUT);

  localparam logic [ENT_W-1:0] LAST_ENT = ENT_W'(ENTRIES - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(DIM - 1);
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(HEX_DIGITS - 1);
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(ACK_TIMEOUT - 1);

  tx_state_t            state, state_n;
  logic [RES_WIDTH-1:0] snap [ENTRIES];
  logic [ENT_W-1:0]     entry_idx;
  logic [COL_W-1:0]     col_idx;
  logic [DIG_W-1:0]     digit_idx;
  logic                 in_sep;
  logic                 sep_phase;
  logic [TMO_W-1:0]     tmo_cnt;

  logic [RES_WIDTH-1:0] cur_entry;
  logic [3:0]           cur_nibble;
  logic [7:0]           hex_char;
  logic [7:0]           next_byte;
  logic                 last_byte;

  // Pick the current entry and its nibble, most significant digit first
  always_comb begin
    cur_entry  = snap[entry_idx];
    cur_nibble = '0;
    for (int d = 0; d < HEX_DIGITS; d++) begin
      if (digit_idx == DIG_W'(d)) begin
        cur_nibble = cur_entry[(HEX_DIGITS-1-d)*4 +: 4];
      end
    end
  end

  nibble_to_ascii u_nibble_to_ascii (
    .nibble (cur_nibble),
    .ascii  (hex_char)
  );

  // Byte for the current position: hex digit, space between columns, CR LF at row end
  always_comb begin
    next_byte = hex_char;
    last_byte = 1'b0;
    if (in_sep) begin
      if (col_idx != LAST_COL) begin
        next_byte = ASCII_SPACE;
      end else if (!sep_phase) begin
        next_byte = ASCII_CR;
      end else begin
        next_byte = ASCII_LF;
        last_byte = (entry_idx == LAST_ENT);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and handshake outputs; tx_start only fires in SEND while uart_tx is idle
  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (res_valid) state_n = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        busy = 1'b1;
        if (tx_busy || (tmo_cnt == LAST_TMO)) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (!tx_busy) state_n = last_byte ? DONE : LOAD;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Snapshot capture, byte register, ack timeout and byte-position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < ENTRIES; n++) snap[n] <= '0;
      tx_data   <= 8'h00;
      entry_idx <= '0;
      col_idx   <= '0;
      digit_idx <= '0;
      in_sep    <= 1'b0;
      sep_phase <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (res_valid) begin
            for (int n = 0; n < ENTRIES; n++) snap[n] <= res_flat[n*RES_WIDTH +: RES_WIDTH];
            entry_idx <= '0;
            col_idx   <= '0;
            digit_idx <= '0;
            in_sep    <= 1'b0;
            sep_phase <= 1'b0;
          end
        end
        LOAD: tx_data <= next_byte;
        SEND: tmo_cnt <= '0;
        WAIT_ACK: begin
          if (!tx_busy && (tmo_cnt != LAST_TMO)) tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        WAIT_DONE: begin
          if (!tx_busy && !last_byte) begin
            if (!in_sep) begin
              if (digit_idx == LAST_DIG) begin
                digit_idx <= '0;
                in_sep    <= 1'b1;
              end else begin
                digit_idx <= digit_idx + DIG_W'(1);
              end
            end else if (col_idx != LAST_COL) begin
              in_sep    <= 1'b0;
              col_idx   <= col_idx + COL_W'(1);
              entry_idx <= entry_idx + ENT_W'(1);
            end else if (!sep_phase) begin
              sep_phase <= 1'b1;
            end else begin
              in_sep    <= 1'b0;
              sep_phase <= 1'b0;
              col_idx   <= '0;
              if (entry_idx != LAST_ENT) entry_idx <= entry_idx + ENT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
